// File: rtl/mac_rr_arbiter.sv
// mac_rr_arbiter: shares one fixed-latency MAC between NREQ requesters with
// round-robin arbitration, and tags each result with the requester index.
// Optional feature macro: MAC_RR_ARBITER_PERF_CNT_EN adds perf_busy[31:0],
// a saturating count of cycles in which an operand transfer took place.
//
// Handshake: a requester transfer happens in a cycle where
// req_valid[i] && req_ready[i]; a result transfer happens in a cycle where
// out_valid && out_ready. While out_valid is high and out_ready is low the
// whole pipeline (including the MAC via mac_en) is frozen, so out_valid,
// out_id and dataout stay stable and no request is accepted.
module mac_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 4,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock,
  input  logic                 areset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [32*NREQ-1:0]   req_c,
  output logic [15:0]          mac_a,
  output logic [15:0]          mac_b,
  output logic [31:0]          mac_c,
  output logic                 mac_en,
  output logic                 mac_areset,
  input  logic [15:0]          mac_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDW-1:0]       out_id,
  output logic [15:0]          dataout
`ifdef MAC_RR_ARBITER_PERF_CNT_EN
  ,
  output logic [31:0]          perf_busy
`endif
);

  logic               en;
  logic [IDW-1:0]     rr_ptr;
  logic               xfer;
  logic [IDW-1:0]     gnt_id;
  int                 idx;
  logic [LATENCY-1:0] vld_sr;
  logic [IDW-1:0]     id_sr [LATENCY];

  assign en         = !(out_valid && !out_ready);
  assign mac_en     = en;
  assign mac_areset = areset;
  assign dataout    = mac_q;
  assign out_valid  = vld_sr[LATENCY-1];
  assign out_id     = id_sr[LATENCY-1];

  // Round-robin search from rr_ptr upward; route the winner's operands to the MAC.
  always_comb begin
    xfer      = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    req_ready = '0;
    mac_a     = '0;
    mac_b     = '0;
    mac_c     = '0;
    if (en && !areset) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!xfer && req_valid[idx]) begin
          xfer   = 1'b1;
          gnt_id = IDW'(idx);
          mac_a  = req_a[16*idx +: 16];
          mac_b  = req_b[16*idx +: 16];
          mac_c  = req_c[32*idx +: 32];
        end
      end
    end
    if (xfer) req_ready[gnt_id] = 1'b1;
  end

  // Pointer moves just past the last winner; holds when nothing transfers.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Valid/ID shift register mirrors the MAC pipeline and advances with it.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) id_sr[i] <= '0;
    end else if (en) begin
      vld_sr[0] <= xfer;
      id_sr[0]  <= gnt_id;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        id_sr[i]  <= id_sr[i-1];
      end
    end
  end

`ifdef MAC_RR_ARBITER_PERF_CNT_EN
  // Saturating count of transfer cycles.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      perf_busy <= '0;
    end else if (xfer && (perf_busy != 32'hFFFF_FFFF)) begin
      perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// tb_mac_rr_arbiter: randomized and directed stimulus for mac_rr_arbiter,
// checked every cycle against a transaction-level reference model.
module tb_mac_rr_arbiter;
  localparam int NREQ    = 4;
  localparam int LATENCY = 4;
  localparam int IDW     = 2;
  localparam int EW      = 32 + IDW + 16;

  logic              clock = 1'b0;
  logic              areset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [32*NREQ-1:0] req_c;
  logic [15:0]       mac_a, mac_b;
  logic [31:0]       mac_c;
  logic              mac_en, mac_areset;
  logic [15:0]       mac_q;
  logic              out_valid, out_ready;
  logic [IDW-1:0]    out_id;
  logic [15:0]       dataout;
`ifdef MAC_RR_ARBITER_PERF_CNT_EN
  logic [31:0]       perf_busy;
`endif

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  mac_rr_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clock(clock), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_en(mac_en), .mac_areset(mac_areset), .mac_q(mac_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .dataout(dataout)
`ifdef MAC_RR_ARBITER_PERF_CNT_EN
    , .perf_busy(perf_busy)
`endif
  );

  // ---------------- half/single float helpers ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    if (h[14:10] == 5'd0) return 0.0;
    v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    real v;
    if (f[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
    return f[31] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic s;
    int e, m;
    real r;
    s = 1'b0;
    r = x;
    e = 0;
    if (r < 0.0) begin s = 1'b1; r = -r; end
    if (r == 0.0) return {s, 15'd0};
    for (int i = 0; i < 200 && r >= 2.0; i++) begin r = r / 2.0; e++; end
    for (int i = 0; i < 200 && r < 1.0; i++) begin r = r * 2.0; e--; end
    if (e > 15)  return {s, 5'h1f, 10'd0};
    if (e < -14) return {s, 15'd0};
    m = $rtoi((r - 1.0) * 1024.0);
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  function automatic logic [15:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [31:0] c);
    return r2h(h2r(a) * h2r(b) + f2r(c));
  endfunction

  // ---------------- MAC stub: LATENCY enabled stages ----------------
  logic [15:0] mac_pipe [LATENCY];
  always @(posedge clock or posedge mac_areset) begin
    if (mac_areset) begin
      for (int i = 0; i < LATENCY; i++) mac_pipe[i] <= 16'd0;
    end else if (mac_en) begin
      mac_pipe[0] <= mac_fn(mac_a, mac_b, mac_c);
      for (int i = 1; i < LATENCY; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
  end
  assign mac_q = mac_pipe[LATENCY-1];

  // ---------------- scoreboard / reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];   // {due enabled-cycle, id, data}
  int grant_log[$];
  int m_rr   = 0;
  int en_cnt = 0;
  int xfer_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle compare against the transaction model; outputs sampled mid-cycle.
  always @(negedge clock) begin
    int g, idx, due;
    logic e_ov, e_en;
    logic [NREQ-1:0] e_rdy;
    logic [15:0] ea, eb;
    logic [31:0] ec;
    chk("mac_areset", 64'(mac_areset), 64'(areset));
    if (areset) begin
      m_rr = 0;
      xfer_cnt = 0;
      exp_q.delete();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_id", 64'(out_id), 64'd0);
`ifdef MAC_RR_ARBITER_PERF_CNT_EN
      chk("rst_perf_busy", 64'(perf_busy), 64'd0);
`endif
    end else begin
      e_ov = 1'b0;
      if (exp_q.size() > 0) begin
        due = int'(exp_q[0][EW-1 -: 32]);
        e_ov = (due == en_cnt);
      end
      e_en = !(e_ov && !out_ready);
      chk("mac_en", 64'(mac_en), 64'(e_en));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      if (e_ov) begin
        chk("out_id", 64'(out_id), 64'(exp_q[0][16 +: IDW]));
        chk("dataout", 64'(dataout), 64'(exp_q[0][15:0]));
      end
`ifdef MAC_RR_ARBITER_PERF_CNT_EN
      chk("perf_busy", 64'(perf_busy), 64'(xfer_cnt));
`endif
      g = -1;
      if (e_en) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      e_rdy = '0;
      ea = '0; eb = '0; ec = '0;
      if (g >= 0) begin
        e_rdy[g] = 1'b1;
        ea = req_a[16*g +: 16];
        eb = req_b[16*g +: 16];
        ec = req_c[32*g +: 32];
      end
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("mac_a", 64'(mac_a), 64'(ea));
      chk("mac_b", 64'(mac_b), 64'(eb));
      chk("mac_c", 64'(mac_c), 64'(ec));
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
      if (e_ov && out_ready) void'(exp_q.pop_front());
      if (g >= 0) begin
        exp_q.push_back({32'(en_cnt + LATENCY), IDW'(g), mac_fn(ea, eb, ec)});
        m_rr = (g + 1) % NREQ;
        xfer_cnt++;
      end
      if (e_en) en_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
      req_b[16*i +: 16] = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
      req_c[32*i +: 32] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req_valid = '0;
    step();
    step();
    areset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    areset = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    req_a = '0; req_b = '0; req_c = '0;
    repeat (3) step();
    areset = 1'b0;

    // Single request from req0: 2.0 * 3.0 + 1.0 = 7.0
    req_a[15:0] = 16'h4000;
    req_b[15:0] = 16'h4200;
    req_c[31:0] = 32'h3F80_0000;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    n = 1;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("single_latency", 64'(n), 64'd4);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_id", 64'(out_id), 64'd0);
    chk("single_data", 64'(dataout), 64'h4700);
    repeat (3) step();

`ifdef MAC_RR_ARBITER_PERF_CNT_EN
    // Ten back-to-back transfers.
    do_reset();
    req_valid = 4'b0001;
    repeat (10) step();
    req_valid = '0;
    step();
    chk("perf_ten", 64'(perf_busy), 64'd10);
    repeat (5) step();
`endif

    // All requesters valid continuously.
    do_reset();
    grant_log.delete();
    rand_ops();
    req_valid = 4'hF;
    repeat (12) begin step(); rand_ops(); end
    chk("all_gnt_count", 64'(grant_log.size()), 64'd12);
    for (int k = 0; k < 8; k++) chk("all_gnt_order", 64'(grant_log[k]), 64'(k % 4));

    // Only req2/req3 valid, starting from rr_ptr = 3.
    do_reset();
    req_valid = 4'b0100;
    step();
    grant_log.delete();
    req_valid = 4'b1100;
    repeat (4) step();
    chk("pair_count", 64'(grant_log.size()), 64'd4);
    chk("pair_g0", 64'(grant_log[0]), 64'd3);
    chk("pair_g1", 64'(grant_log[1]), 64'd2);
    chk("pair_g2", 64'(grant_log[2]), 64'd3);
    chk("pair_g3", 64'(grant_log[3]), 64'd2);

    // Downstream stall for 5 cycles with results pending.
    req_valid = 4'hF;
    repeat (6) begin step(); rand_ops(); end
    out_ready = 1'b0;
    repeat (5) step();
    chk("stall_mac_en", 64'(mac_en), 64'd0);
    chk("stall_ready", 64'(req_ready), 64'd0);
    out_ready = 1'b1;
    repeat (10) begin step(); rand_ops(); end

    // Reset pulse with results in flight.
    #2 areset = 1'b1;
    step();
    areset = 1'b0;
    grant_log.delete();
    repeat (8) begin step(); rand_ops(); end
    chk("post_rst_first", 64'(grant_log[0]), 64'd0);

    // Randomized traffic with occasional stalls and resets.
    for (int c = 0; c < 500; c++) begin
      rand_ops();
      req_valid = NREQ'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      areset    = ($urandom_range(0, 99) == 0);
      step();
    end
    areset = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
